// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 scan-code stream to one-cycle Tetris move requests (left/right/rotate/down/drop).
// Latency: one cycle from byte strobe to pulse/held update; all outputs registered.
// Backpressure: none, every strobed byte is consumed; optional auto-repeat under macro PS2_AUTOREPEAT_EN.
module ps2_move_decoder #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic       rotate_pulse,
    output logic       down_pulse,
    output logic       drop_pulse,
    output logic [4:0] held
);

    // Key bit positions shared by held, pulse and owner vectors:
    // 0 left, 1 right, 2 rotate, 3 down, 4 drop.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t     r_state;
    logic [4:0] r_held;
    logic [4:0] r_pulse;

    logic [4:0] w_make;
    logic [4:0] w_brk;
    logic [4:0] w_fresh;
    logic [4:0] w_rep_pulse;

    // Both counts must be at least one cycle for the repeat compare thresholds to make sense.
    generate
        if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
            $error("ps2_move_decoder: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
        end
    endgenerate

    // Map the second byte of an E0-prefixed code onto the arrow-key bits.
    function automatic logic [4:0] ext_key(input logic [7:0] code);
        logic [4:0] k;
        k = 5'b00000;
        case (code)
            8'h6B:   k = 5'b00001;
            8'h74:   k = 5'b00010;
            8'h75:   k = 5'b00100;
            8'h72:   k = 5'b01000;
            default: k = 5'b00000;
        endcase
        return k;
    endfunction

    // Decode the strobed byte in the context of the current prefix state into make/break vectors.
    always_comb begin
        w_make = 5'b00000;
        w_brk  = 5'b00000;
        if (ps2_key_pressed) begin
            case (r_state)
                ST_IDLE:    if (ps2_key_data == 8'h29) w_make[4] = 1'b1;
                ST_EXT:     w_make = ext_key(ps2_key_data);
                ST_BRK:     if (ps2_key_data == 8'h29) w_brk[4] = 1'b1;
                ST_EXT_BRK: w_brk = ext_key(ps2_key_data);
                default: begin
                    w_make = 5'b00000;
                    w_brk  = 5'b00000;
                end
            endcase
        end
    end

    // Keyboard typematic repeats arrive as makes of an already-held key; only a first make counts.
    assign w_fresh = w_make & ~r_held;

`ifdef PS2_AUTOREPEAT_EN
    // Left, right and down repeat; rotate and drop never do.
    localparam logic [4:0]  LP_REP_MASK  = 5'b01011;
    localparam logic [31:0] LP_DELAY_M1  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] LP_PERIOD_M1 = 32'(REPEAT_PERIOD - 1);

    logic [4:0]  r_owner;
    logic [31:0] r_cnt;
    logic        r_first;

    logic [4:0] w_rep_new;
    logic       w_own_brk;
    logic       w_fire;

    assign w_rep_new = w_fresh & LP_REP_MASK;
    assign w_own_brk = |(w_brk & r_owner);
    // Counter is 0 in the cycle after the make, so DELAY-1 here gives a pulse DELAY+1 cycles after the strobe.
    assign w_fire    = (|r_owner) && (r_cnt == (r_first ? LP_DELAY_M1 : LP_PERIOD_M1));
    // A new repeatable make or the owner's own break on this cycle suppresses the pending repeat.
    assign w_rep_pulse = (w_fire && !w_own_brk && !(|w_rep_new)) ? r_owner : 5'b00000;

    // Track the single repeat owner and its delay/period counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_owner <= 5'b00000;
            r_cnt   <= 32'd0;
            r_first <= 1'b1;
        end else if (|w_rep_new) begin
            r_owner <= w_rep_new;
            r_cnt   <= 32'd0;
            r_first <= 1'b1;
        end else if (w_own_brk) begin
            r_owner <= 5'b00000;
            r_cnt   <= 32'd0;
            r_first <= 1'b1;
        end else if (|r_owner) begin
            if (w_fire) begin
                r_cnt   <= 32'd0;
                r_first <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end
`else
    assign w_rep_pulse = 5'b00000;
`endif

    // Prefix FSM plus registered held flags and move pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_held  <= 5'b00000;
            r_pulse <= 5'b00000;
        end else begin
            r_pulse <= w_fresh | w_rep_pulse;
            r_held  <= (r_held | w_make) & ~w_brk;
            if (ps2_key_pressed) begin
                case (r_state)
                    ST_IDLE: begin
                        if (ps2_key_data == 8'hE0)      r_state <= ST_EXT;
                        else if (ps2_key_data == 8'hF0) r_state <= ST_BRK;
                        else                            r_state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (ps2_key_data == 8'hF0) r_state <= ST_EXT_BRK;
                        else                       r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign left_pulse   = r_pulse[0];
    assign right_pulse  = r_pulse[1];
    assign rotate_pulse = r_pulse[2];
    assign down_pulse   = r_pulse[3];
    assign drop_pulse   = r_pulse[4];
    assign held         = r_held;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Bench for ps2_move_decoder: directed table, timed repeat sequences, reset mid-prefix, random bytes.
// Latency: outputs sampled 2 ns after each rising edge, one cycle after the driving strobe.
// Backpressure: none; the stimulus drives one byte per strobed cycle.
module tb_ps2_move_decoder;

    localparam int D = 20;
    localparam int P = 5;
`ifdef PS2_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic       left_pulse, right_pulse, rotate_pulse, down_pulse, drop_pulse;
    logic [4:0] held;

    always #5 clock = ~clock;

    ps2_move_decoder #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ps2_key_data   (ps2_key_data),
        .ps2_key_pressed(ps2_key_pressed),
        .left_pulse     (left_pulse),
        .right_pulse    (right_pulse),
        .rotate_pulse   (rotate_pulse),
        .down_pulse     (down_pulse),
        .drop_pulse     (drop_pulse),
        .held           (held)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [4:0] cur_p;

    // Reference model: pending byte sequence, held set, repeat owner and its make time.
    logic [7:0] pq[$];
    logic [4:0] m_held;
    int         m_owner;
    int         m_own_t;
    logic [4:0] exp_p;

    typedef struct {
        logic       stb;
        logic [7:0] d;
        logic [4:0] p;
        logic [4:0] h;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
        end
    endtask

    function automatic int code_key(input bit ext, input logic [7:0] b);
        if (ext) begin
            case (b)
                8'h6B:   return 0;
                8'h74:   return 1;
                8'h75:   return 2;
                8'h72:   return 3;
                default: return -1;
            endcase
        end
        return (b == 8'h29) ? 4 : -1;
    endfunction

    task automatic model_reset();
        pq.delete();
        m_held  = 5'b0;
        m_owner = -1;
        m_own_t = 0;
    endtask

    // Expected outputs for the cycle after input cycle 'cyc'.
    task automatic model_step(input bit stb, input logic [7:0] d);
        int  sz, k, mk, bk, ro;
        bit  keep, ext, isbrk, rep;
        exp_p = 5'b0;
        mk = -1;
        bk = -1;
        if (stb) begin
            pq.push_back(d);
            sz   = pq.size();
            keep = (sz == 1 && (d == 8'hE0 || d == 8'hF0)) || (sz == 2 && pq[0] == 8'hE0 && d == 8'hF0);
            if (!keep) begin
                ext   = (pq[0] == 8'hE0);
                isbrk = (sz == 3) || (sz == 2 && pq[0] == 8'hF0);
                k     = code_key(ext, d);
                if (k >= 0) begin
                    if (isbrk) bk = k;
                    else       mk = k;
                end
                pq.delete();
            end
        end
        ro  = m_owner;
        rep = AR && (ro >= 0) && ((cyc - m_own_t) >= D) && (((cyc - m_own_t - D) % P) == 0);
        if (mk >= 0 && !m_held[mk]) begin
            exp_p[mk]  = 1'b1;
            m_held[mk] = 1'b1;
            if (mk == 0 || mk == 1 || mk == 3) begin
                m_owner = mk;
                m_own_t = cyc;
                rep     = 1'b0;
            end
        end
        if (bk >= 0) begin
            m_held[bk] = 1'b0;
            if (bk == m_owner) begin
                m_owner = -1;
                rep     = 1'b0;
            end
        end
        if (rep) exp_p[ro] = 1'b1;
    endtask

    // One clock: drive inputs, advance the model, sample after the edge and compare.
    task automatic tick(input bit stb, input logic [7:0] d);
        ps2_key_pressed = stb;
        ps2_key_data    = d;
        model_step(stb, d);
        @(posedge clock);
        #2;
        cyc++;
        cur_p = {drop_pulse, down_pulse, rotate_pulse, right_pulse, left_pulse};
        chk("mdl_pulse", 64'(cur_p), 64'(exp_p));
        chk("mdl_held", 64'(held), 64'(m_held));
    endtask

    task automatic do_reset();
        ps2_key_pressed = 1'b0;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        cyc += 3;
        chk("rst_pulse", 64'({drop_pulse, down_pulse, rotate_pulse, right_pulse, left_pulse}), 64'd0);
        chk("rst_held", 64'(held), 64'd0);
        resetn = 1'b1;
    endtask

    task automatic add(input logic s, input logic [7:0] d, input logic [4:0] p, input logic [4:0] h);
        vec_t v;
        v.stb = s; v.d = d; v.p = p; v.h = h;
        tbl.push_back(v);
    endtask

    logic [63:0] mask, exp_mask;
    int          nl;

    initial begin
        // Directed single-key and prefix vectors, each short enough that no repeat can fire.
        add(1, 8'hE0, 5'b00000, 5'b00000); add(1, 8'h6B, 5'b00001, 5'b00001);
        add(0, 8'h00, 5'b00000, 5'b00001); add(1, 8'hE0, 5'b00000, 5'b00001);
        add(1, 8'hF0, 5'b00000, 5'b00001); add(1, 8'h6B, 5'b00000, 5'b00000);
        add(1, 8'hE0, 5'b00000, 5'b00000); add(1, 8'h75, 5'b00100, 5'b00100);
        add(1, 8'hE0, 5'b00000, 5'b00100); add(1, 8'h75, 5'b00000, 5'b00100);
        add(1, 8'hE0, 5'b00000, 5'b00100); add(1, 8'h75, 5'b00000, 5'b00100);
        add(1, 8'hE0, 5'b00000, 5'b00100); add(1, 8'hF0, 5'b00000, 5'b00100);
        add(1, 8'h75, 5'b00000, 5'b00000);
        add(1, 8'h29, 5'b10000, 5'b10000); add(1, 8'h29, 5'b00000, 5'b10000);
        add(1, 8'hF0, 5'b00000, 5'b10000); add(1, 8'h29, 5'b00000, 5'b00000);
        add(1, 8'h29, 5'b10000, 5'b10000); add(1, 8'hF0, 5'b00000, 5'b10000);
        add(1, 8'h29, 5'b00000, 5'b00000);
        add(1, 8'hE0, 5'b00000, 5'b00000); add(1, 8'h72, 5'b01000, 5'b01000);
        add(1, 8'hE0, 5'b00000, 5'b01000); add(1, 8'hF0, 5'b00000, 5'b01000);
        add(1, 8'h72, 5'b00000, 5'b00000);
        add(1, 8'hE1, 5'b00000, 5'b00000); add(1, 8'hE0, 5'b00000, 5'b00000);
        add(1, 8'h12, 5'b00000, 5'b00000); add(1, 8'h6B, 5'b00000, 5'b00000);
        add(0, 8'hE0, 5'b00000, 5'b00000); add(1, 8'h6B, 5'b00000, 5'b00000);
        add(1, 8'hE0, 5'b00000, 5'b00000); add(1, 8'hE0, 5'b00000, 5'b00000);
        add(1, 8'h6B, 5'b00000, 5'b00000); add(1, 8'hF0, 5'b00000, 5'b00000);
        add(1, 8'hE0, 5'b00000, 5'b00000); add(1, 8'h6B, 5'b00000, 5'b00000);
        add(1, 8'hE0, 5'b00000, 5'b00000); add(1, 8'h75, 5'b00100, 5'b00100);
        add(1, 8'h29, 5'b10000, 5'b10100); add(1, 8'hF0, 5'b00000, 5'b10100);
        add(1, 8'h29, 5'b00000, 5'b00100); add(1, 8'hE0, 5'b00000, 5'b00100);
        add(1, 8'hF0, 5'b00000, 5'b00100); add(1, 8'h75, 5'b00000, 5'b00000);

        model_reset();
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].stb, tbl[i].d);
            chk("tbl_pulse", 64'(cur_p), 64'(tbl[i].p));
            chk("tbl_held", 64'(held), 64'(tbl[i].h));
        end

        // Right held 40 cycles: first pulse at +1, repeats at +21, +26, +31, +36.
        exp_mask = 64'd2;
        if (AR) begin
            exp_mask[21] = 1'b1; exp_mask[26] = 1'b1; exp_mask[31] = 1'b1; exp_mask[36] = 1'b1;
        end
        tick(1, 8'hE0);
        tick(1, 8'h74);
        mask = 64'd0;
        mask[1] = cur_p[1];
        for (int off = 2; off <= 40; off++) begin
            tick(0, 8'h00);
            mask[off] = cur_p[1];
        end
        chk("right_repeat_mask", mask, exp_mask);
        tick(1, 8'hE0); tick(1, 8'hF0); tick(1, 8'h74);
        mask = 64'd0;
        for (int off = 1; off <= 30; off++) begin
            tick(0, 8'h00);
            mask[off] = cur_p[1];
        end
        chk("right_after_break", mask, 64'd0);
        chk("right_held_clear", 64'(held), 64'd0);

        // Left held, right pressed 12 cycles later: only right repeats.
        nl = 0;
        tick(1, 8'hE0); tick(1, 8'h6B); nl += int'(cur_p[0]);
        repeat (10) begin tick(0, 8'h00); nl += int'(cur_p[0]); end
        tick(1, 8'hE0); nl += int'(cur_p[0]);
        tick(1, 8'h74); nl += int'(cur_p[0]);
        mask = 64'd0;
        mask[1] = cur_p[1];
        for (int off = 2; off <= 40; off++) begin
            tick(0, 8'h00);
            mask[off] = cur_p[1];
            nl += int'(cur_p[0]);
        end
        chk("owner_xfer_right", mask, exp_mask);
        chk("owner_xfer_left_cnt", 64'(nl), 64'd1);
        chk("two_held", 64'(held), 64'b00011);
        tick(1, 8'hE0); tick(1, 8'hF0); tick(1, 8'h6B);
        tick(1, 8'hE0); tick(1, 8'hF0); tick(1, 8'h74);

        // Reset after a lone E0 prefix: following 6B is a plain, unmapped code.
        tick(1, 8'hE0);
        do_reset();
        tick(1, 8'h6B);
        chk("rst_ext_6b", 64'(cur_p), 64'd0);
        chk("rst_ext_held", 64'(held), 64'd0);

        // Left held 40 cycles alone.
        nl = 0;
        tick(1, 8'hE0); tick(1, 8'h6B); nl += int'(cur_p[0]);
        repeat (39) begin tick(0, 8'h00); nl += int'(cur_p[0]); end
        chk("left_hold_cnt", 64'(nl), AR ? 64'd5 : 64'd1);
        tick(1, 8'hE0); tick(1, 8'hF0); tick(1, 8'h6B);

        // Random byte stream drawn from a pool of meaningful and junk codes.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] pool [10];
            logic [7:0] b;
            pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'hE1, 8'h12, 8'h1C};
            b = pool[$urandom_range(0, 9)];
            tick($urandom_range(0, 7) == 0, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
